mul_bit_iter: RTL and testbench

MUL_BIT_ITER -- requirements
Module: mul_bit_iter

---
 rtl/mul_bit_iter_if.sv | 25 ++
 rtl/mul_bit_iter.sv | 116 +++++++++++
 tb/tb_mul_bit_iter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_bit_iter_if.sv
// Operand, control and result bundle for the bit-serial multiplier.
// master = requester driving operands/exe; slave = multiplier.
interface mul_bit_iter_if #(
    parameter int IN_W  = 18,
    parameter int RES_W = 21
);
    logic [IN_W-1:0]  mul_bit1;
    logic [IN_W-1:0]  mul_bit2;
    logic             mul_bit_signed;
    logic             mul_bit_exe;
    logic             mul_bit_busy;
    logic             mul_bit_done;
    logic [RES_W-1:0] mul_bit_result;
    logic             mul_bit_ovf;

    modport master (
        output mul_bit1, mul_bit2, mul_bit_signed, mul_bit_exe,
        input  mul_bit_busy, mul_bit_done, mul_bit_result, mul_bit_ovf
    );

    modport slave (
        input  mul_bit1, mul_bit2, mul_bit_signed, mul_bit_exe,
        output mul_bit_busy, mul_bit_done, mul_bit_result, mul_bit_ovf
    );
endinterface

// File: rtl/mul_bit_iter.sv
// Radix-2 shift-add multiplier, signed/unsigned, truncating or saturating result.
// Latency IN_W+1 cycles from the exe edge to the done pulse.
// No backpressure: exe is ignored while busy, nothing is queued.
module mul_bit_iter #(
    parameter int IN_W  = 18,
    parameter int RES_W = 21,
    parameter int SAT   = 0
) (
    input  logic         m_clock,
    input  logic         p_reset,
    mul_bit_iter_if.slave bus
);
    localparam int P_W   = 2 * IN_W;
    localparam int CNT_W = $clog2(IN_W);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [IN_W-1:0]  mag_a;
    logic [IN_W-1:0]  mag_b;
    logic             neg;
    logic             sgn_mode;
    logic [P_W-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [RES_W-1:0] result;

    logic [IN_W-1:0]  abs1;
    logic [IN_W-1:0]  abs2;
    logic [IN_W:0]    sum;
    logic [P_W-1:0]   prod;
    logic [P_W-1:0]   prod_hi;
    logic             ovf_n;
    logic [RES_W-1:0] sat_val;
    logic [RES_W-1:0] res_n;

    always_comb begin
        abs1 = (bus.mul_bit_signed && bus.mul_bit1[IN_W-1]) ? -bus.mul_bit1 : bus.mul_bit1;
        abs2 = (bus.mul_bit_signed && bus.mul_bit2[IN_W-1]) ? -bus.mul_bit2 : bus.mul_bit2;
        // Carry out of the upper half is kept and shifts back into the accumulator.
        sum  = {1'b0, acc[P_W-1:IN_W]} + {1'b0, (mag_b[0] ? mag_a : {IN_W{1'b0}})};
    end

    always_comb begin
        prod    = neg ? -acc : acc;
        // Signed fit means every bit from RES_W-1 upward equals the sign bit.
        prod_hi = $signed(prod) >>> (RES_W - 1);
        if (sgn_mode) begin
            ovf_n   = !((prod_hi == {P_W{1'b0}}) || (prod_hi == {P_W{1'b1}}));
            sat_val = neg ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
        end else begin
            ovf_n   = (acc >> RES_W) != {P_W{1'b0}};
            sat_val = {RES_W{1'b1}};
        end
        res_n = ((SAT != 0) && ovf_n) ? sat_val : prod[RES_W-1:0];
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state    <= IDLE;
            mag_a    <= '0;
            mag_b    <= '0;
            neg      <= 1'b0;
            sgn_mode <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.mul_bit_exe) begin
                        mag_a    <= abs1;
                        mag_b    <= abs2;
                        neg      <= bus.mul_bit_signed & (bus.mul_bit1[IN_W-1] ^ bus.mul_bit2[IN_W-1]);
                        sgn_mode <= bus.mul_bit_signed;
                        acc      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= {sum, acc[IN_W-1:1]};
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(IN_W - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    result <= res_n;
                    ovf    <= ovf_n;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mul_bit_busy   = busy;
    assign bus.mul_bit_done   = done;
    assign bus.mul_bit_result = result;
    assign bus.mul_bit_ovf    = ovf;
endmodule

// File: tb/tb_mul_bit_iter.sv
// Bench: truncating and saturating instances driven in lockstep, checked against an arithmetic model.
module tb_mul_bit_iter;
    localparam int IN_W  = 18;
    localparam int RES_W = 21;
    localparam int LAT   = IN_W + 1;

    logic m_clock = 1'b0;
    logic p_reset = 1'b0;
    always #5 m_clock = ~m_clock;

    mul_bit_iter_if #(.IN_W(IN_W), .RES_W(RES_W)) ift ();
    mul_bit_iter_if #(.IN_W(IN_W), .RES_W(RES_W)) ifs ();

    mul_bit_iter #(.IN_W(IN_W), .RES_W(RES_W), .SAT(0)) u_trunc (
        .m_clock(m_clock), .p_reset(p_reset), .bus(ift.slave)
    );
    mul_bit_iter #(.IN_W(IN_W), .RES_W(RES_W), .SAT(1)) u_sat (
        .m_clock(m_clock), .p_reset(p_reset), .bus(ifs.slave)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                         input logic s, input logic exe);
        ift.mul_bit1 = a; ift.mul_bit2 = b; ift.mul_bit_signed = s; ift.mul_bit_exe = exe;
        ifs.mul_bit1 = a; ifs.mul_bit2 = b; ifs.mul_bit_signed = s; ifs.mul_bit_exe = exe;
    endtask

    // Full product in 64-bit arithmetic, then range test and policy.
    task automatic model(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b, input logic s,
                         output logic [RES_W-1:0] res_t, output logic [RES_W-1:0] res_s,
                         output logic ovf);
        longint pa, pb, p, lo, hi, umax;
        pa   = s ? longint'($signed(a)) : longint'(a);
        pb   = s ? longint'($signed(b)) : longint'(b);
        p    = pa * pb;
        lo   = -(longint'(1) <<< (RES_W - 1));
        hi   = (longint'(1) <<< (RES_W - 1)) - 1;
        umax = (longint'(1) <<< RES_W) - 1;
        ovf  = s ? (p < lo || p > hi) : (p > umax);
        res_t = RES_W'(p);
        if (!ovf)        res_s = res_t;
        else if (!s)     res_s = RES_W'(umax);
        else if (p < 0)  res_s = RES_W'(lo);
        else             res_s = RES_W'(hi);
    endtask

    task automatic wait_done(input int budget, output int cyc, output int busy_n);
        cyc = 0;
        busy_n = 0;
        while (ift.mul_bit_done !== 1'b1 && cyc < budget) begin
            if (ift.mul_bit_busy === 1'b1) busy_n++;
            @(posedge m_clock); #1;
            cyc++;
        end
        chk("done_seen", ift.mul_bit_done, 1);
        chk("sat_done_sync", ifs.mul_bit_done, 1);
        chk("busy_low_at_done", ift.mul_bit_busy, 0);
    endtask

    task automatic check_result(input string tag, input logic [IN_W-1:0] a,
                                input logic [IN_W-1:0] b, input logic s);
        logic [RES_W-1:0] rt, rs;
        logic ov;
        model(a, b, s, rt, rs, ov);
        chk({tag, "_trunc_res"}, ift.mul_bit_result, rt);
        chk({tag, "_trunc_ovf"}, ift.mul_bit_ovf, ov);
        chk({tag, "_sat_res"}, ifs.mul_bit_result, rs);
        chk({tag, "_sat_ovf"}, ifs.mul_bit_ovf, ov);
    endtask

    task automatic run_op(input string tag, input logic [IN_W-1:0] a,
                          input logic [IN_W-1:0] b, input logic s);
        int cyc, bn;
        @(negedge m_clock);
        drive(a, b, s, 1'b1);
        @(posedge m_clock); #1;
        drive(IN_W'($urandom), IN_W'($urandom), 1'($urandom), 1'b0);
        wait_done(LAT + 10, cyc, bn);
        chk({tag, "_latency"}, cyc, LAT);
        chk({tag, "_busy_cycles"}, bn, LAT);
        check_result(tag, a, b, s);
    endtask

    function automatic logic [IN_W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return IN_W'(1);
            2:       return '1;
            3:       return {1'b1, {(IN_W-1){1'b0}}};
            default: return IN_W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [IN_W-1:0] a, b, c, d;
        logic [RES_W-1:0] hold_t, hold_s;
        int cyc, bn;

        drive('0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge m_clock);
        #1;
        chk("rst_busy", ift.mul_bit_busy, 0);
        chk("rst_done", ift.mul_bit_done, 0);
        chk("rst_result", ift.mul_bit_result, 0);
        chk("rst_ovf", ifs.mul_bit_ovf, 0);
        @(negedge m_clock);
        p_reset = 1'b1;

        run_op("u3x5", IN_W'(3), IN_W'(5), 1'b0);
        chk("spec_3x5", ift.mul_bit_result, 15);
        run_op("u1000x3000", IN_W'(1000), IN_W'(3000), 1'b0);
        chk("spec_1000x3000_t", ift.mul_bit_result, 902848);
        chk("spec_1000x3000_s", ifs.mul_bit_result, 2097151);
        chk("spec_1000x3000_ovf", ift.mul_bit_ovf, 1);
        run_op("s_m7x6", IN_W'(-7), IN_W'(6), 1'b1);
        chk("spec_m7x6", ift.mul_bit_result, 21'h1FFFD6);
        chk("spec_m7x6_ovf", ift.mul_bit_ovf, 0);
        run_op("s_min2", {1'b1, {(IN_W-1){1'b0}}}, {1'b1, {(IN_W-1){1'b0}}}, 1'b1);
        chk("spec_min2_sat", ifs.mul_bit_result, 21'h0FFFFF);
        chk("spec_min2_ovf", ifs.mul_bit_ovf, 1);
        run_op("s_minx1", {1'b1, {(IN_W-1){1'b0}}}, IN_W'(1), 1'b1);
        run_op("s_big_neg", {1'b1, {(IN_W-1){1'b0}}}, IN_W'(100), 1'b1);
        run_op("u_max", '1, '1, 1'b0);

        // Outputs must hold between done pulses.
        hold_t = ift.mul_bit_result;
        hold_s = ifs.mul_bit_result;
        repeat (4) @(posedge m_clock);
        #1;
        chk("hold_trunc", ift.mul_bit_result, hold_t);
        chk("hold_sat", ifs.mul_bit_result, hold_s);

        for (int i = 0; i < 30; i++) begin
            run_op("rand", pick(), pick(), 1'($urandom));
        end

        // exe mid-operation with other operands is dropped.
        a = IN_W'(1234); b = IN_W'(567);
        @(negedge m_clock);
        drive(a, b, 1'b0, 1'b1);
        @(posedge m_clock); #1;
        drive('0, '0, 1'b0, 1'b0);
        repeat (5) @(posedge m_clock);
        #1;
        drive(IN_W'(77), IN_W'(88), 1'b1, 1'b1);
        @(posedge m_clock); #1;
        drive('0, '0, 1'b0, 1'b0);
        wait_done(LAT + 10, cyc, bn);
        chk("ign_latency", cyc + 6, LAT);
        check_result("ign", a, b, 1'b0);
        @(posedge m_clock); #1;
        chk("ign_no_queue", ift.mul_bit_busy, 0);

        // exe held high across done: second op starts on the edge after done.
        a = IN_W'(-300); b = IN_W'(41);
        c = IN_W'(9999); d = IN_W'(250);
        @(negedge m_clock);
        drive(a, b, 1'b1, 1'b1);
        @(posedge m_clock); #1;
        drive(c, d, 1'b0, 1'b1);
        wait_done(LAT + 10, cyc, bn);
        chk("b2b_first_latency", cyc, LAT);
        check_result("b2b_first", a, b, 1'b1);
        @(posedge m_clock); #1;
        drive('0, '0, 1'b0, 1'b0);
        chk("b2b_busy_nogap", ift.mul_bit_busy, 1);
        chk("b2b_done_pulse", ift.mul_bit_done, 0);
        wait_done(LAT + 10, cyc, bn);
        chk("b2b_gap_cycles", cyc, LAT);
        check_result("b2b_second", c, d, 1'b0);

        // Reset at RUN cycle 10 clears everything at once.
        @(negedge m_clock);
        drive(IN_W'(500), IN_W'(500), 1'b0, 1'b1);
        @(posedge m_clock); #1;
        drive('0, '0, 1'b0, 1'b0);
        repeat (10) @(posedge m_clock);
        #1;
        chk("pre_rst_busy", ift.mul_bit_busy, 1);
        p_reset = 1'b0;
        #1;
        chk("mid_rst_busy", ift.mul_bit_busy, 0);
        chk("mid_rst_done", ift.mul_bit_done, 0);
        chk("mid_rst_result", ift.mul_bit_result, 0);
        chk("mid_rst_ovf", ift.mul_bit_ovf, 0);
        chk("mid_rst_sat_result", ifs.mul_bit_result, 0);
        @(negedge m_clock);
        p_reset = 1'b1;
        run_op("after_rst", IN_W'(2), IN_W'(2), 1'b0);
        chk("spec_2x2", ift.mul_bit_result, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
